// File: rtl/cmp_core.sv
// Registered unsigned/signed magnitude comparator producing GT and EQ flags.
// Optional input staging registers are enabled by defining CMP_INPUT_REG_EN.
module cmp_core #(
  parameter int unsigned WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             unsignedGL,
  output logic             signedGL,
  output logic             equal
);

  logic [WIDTH-1:0] xc;
  logic [WIDTH-1:0] yc;

`ifdef CMP_INPUT_REG_EN
  logic [WIDTH-1:0] xq;
  logic [WIDTH-1:0] yq;

  always_ff @(posedge clk) begin
    if (rst) begin
      xq <= '0;
      yq <= '0;
    end else begin
      xq <= x;
      yq <= y;
    end
  end

  assign xc = xq;
  assign yc = yq;
`else
  assign xc = x;
  assign yc = y;
`endif

  logic [WIDTH:0] diff;
  logic           borrow;
  logic           zeroF;
  logic           negF;
  logic           ovfF;
  logic           uGtNext;
  logic           sGtNext;

  // Signed ordering comes from N^V of the subtraction, so the
  // most-negative vs most-positive case needs no special handling.
  always_comb begin
    diff    = {1'b0, xc} - {1'b0, yc};
    borrow  = diff[WIDTH];
    zeroF   = (diff[WIDTH-1:0] == '0);
    negF    = diff[WIDTH-1];
    ovfF    = (xc[WIDTH-1] ^ yc[WIDTH-1]) & (xc[WIDTH-1] ^ negF);
    uGtNext = ~borrow & ~zeroF;
    sGtNext = ~(negF ^ ovfF) & ~zeroF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      unsignedGL <= 1'b0;
      signedGL   <= 1'b0;
      equal      <= 1'b0;
    end else begin
      unsignedGL <= uGtNext;
      signedGL   <= sGtNext;
      equal      <= zeroF;
    end
  end

endmodule

// File: tb/tb_cmp_core.sv
// Directed self-checking bench for cmp_core; expected flags are hand-computed
// per vector as {unsignedGL, signedGL, equal}.
module tb_cmp_core;

  logic       clk;
  logic       rst;
  logic [5:0] x;
  logic [5:0] y;
  logic       unsignedGL;
  logic       signedGL;
  logic       equal;

  int nChecks;
  int nPass;
  int nFail;

  // Expected flags of the operands currently held in the input stage.
  logic [2:0] stageExp;

  cmp_core #(.WIDTH(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .x          (x),
    .y          (y),
    .unsignedGL (unsignedGL),
    .signedGL   (signedGL),
    .equal      (equal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic r, input logic [5:0] a, input logic [5:0] b,
                      input logic [2:0] vecExp, input string tag);
    logic [2:0] expOut;
    logic [2:0] got;
    @(negedge clk);
    rst = r;
    x   = a;
    y   = b;
    @(posedge clk);
    #1;
`ifdef CMP_INPUT_REG_EN
    expOut   = r ? 3'b000 : stageExp;
    stageExp = r ? 3'b001 : vecExp;
`else
    expOut = r ? 3'b000 : vecExp;
`endif
    got = {unsignedGL, signedGL, equal};
    nChecks++;
    assert (got === expOut) nPass++;
    else begin
      nFail++;
      $error("FAIL %s: got U/S/E=%b expected %b", tag, got, expOut);
    end
  endtask

  initial begin
    nChecks  = 0;
    nPass    = 0;
    nFail    = 0;
    stageExp = 3'b001;
    rst      = 1'b1;
    x        = 6'b000101;
    y        = 6'b000001;

    step(1'b1, 6'b000101, 6'b000001, 3'b110, "reset0");
    step(1'b1, 6'b000101, 6'b000001, 3'b110, "reset1");

    step(1'b0, 6'b100000, 6'b111111, 3'b000, "neg32_vs_neg1");
    step(1'b0, 6'b100000, 6'b100000, 3'b001, "equal_min");
    step(1'b0, 6'b000101, 6'b100111, 3'b010, "pos_vs_neg_a");
    step(1'b0, 6'b001100, 6'b101101, 3'b010, "pos_vs_neg_b");
    step(1'b0, 6'b111111, 6'b000000, 3'b100, "max_vs_zero");
    step(1'b0, 6'b011111, 6'b100000, 3'b010, "maxpos_vs_minneg");
    step(1'b0, 6'b100000, 6'b011111, 3'b100, "minneg_vs_maxpos");

    // Back-to-back operands with a one-cycle reset pulse in the middle.
    step(1'b0, 6'b000011, 6'b000010, 3'b110, "b2b_gt");
    step(1'b0, 6'b000001, 6'b000001, 3'b001, "b2b_eq");
    step(1'b1, 6'b111000, 6'b000111, 3'b100, "b2b_rst");
    step(1'b0, 6'b000111, 6'b111000, 3'b010, "b2b_after_rst");
    step(1'b0, 6'b101010, 6'b101011, 3'b000, "b2b_neg_lt");
    step(1'b0, 6'b110000, 6'b010000, 3'b100, "msb_only_a");
    step(1'b0, 6'b010000, 6'b110000, 3'b010, "msb_only_b");
    step(1'b0, 6'b000000, 6'b000001, 3'b000, "zero_lt_one");
    step(1'b0, 6'b000000, 6'b000001, 3'b000, "drain");

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
